// File: rtl/seqplu_sched_if.sv
// Handshake and pulse bundle between burst-request control and the phase-pulse scheduler.
// The master side requests bursts; the slave side (the scheduler) returns the phase pulses and status.
interface seqplu_sched_if #(
   parameter int NPH = 4,
   parameter int WW  = 4,
   parameter int CW  = 8
);
   localparam int PW = (NPH > 1) ? $clog2(NPH) : 1;

   logic          start;
   logic          abort;
   logic [WW-1:0] width;
   logic [WW-1:0] gap;
   logic [CW-1:0] rounds;
   logic          dir;
   logic [NPH-1:0] q;
   logic [PW-1:0]  phase;
   logic           busy;
   logic           done;

   modport master (
      output start, abort, width, gap, rounds, dir,
      input  q, phase, busy, done
   );

   modport slave (
      input  start, abort, width, gap, rounds, dir,
      output q, phase, busy, done
   );
endinterface

// File: rtl/seqplu_sched.sv
// Programmable 4-phase sequential pulse scheduler: one-hot phase pulses with configurable
// width, inter-round gap, round count and direction under a start/abort handshake.
module seqplu_sched #(
   parameter int NPH = 4,
   parameter int WW  = 4,
   parameter int CW  = 8
) (
   input  logic clk,
   input  logic rst,
   seqplu_sched_if.slave bus
);
   localparam int PW = (NPH > 1) ? $clog2(NPH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [PW-1:0] PH_LAST = PW'(NPH - 1);

   logic [1:0]     state_r, state_s;
   logic [PW-1:0]  ph_r, ph_s;
   logic [WW-1:0]  wcnt_r, wcnt_s;
   logic [WW-1:0]  gcnt_r, gcnt_s;
   logic [CW-1:0]  rcnt_r, rcnt_s;
   logic [WW-1:0]  width_r, gap_r;
   logic [CW-1:0]  rounds_r;
   logic           dir_r;
   logic           load_s, abort_s;
   logic           phase_end_s, last_ph_s;
   logic [PW-1:0]  first_ph_s;
   logic [CW-1:0]  rnext_s;
   logic [NPH-1:0] q_r;
   logic [PW-1:0]  phase_r;
   logic           busy_r, done_r;

   function automatic logic [NPH-1:0] onehot(input logic [PW-1:0] idx);
      logic [NPH-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Next-state and counter logic of the scheduling core; outputs trail it by one register stage.
   always_comb begin
      state_s     = state_r;
      ph_s        = ph_r;
      wcnt_s      = wcnt_r;
      gcnt_s      = gcnt_r;
      rcnt_s      = rcnt_r;
      load_s      = 1'b0;
      abort_s     = 1'b0;
      rnext_s     = rcnt_r + CW'(1);
      phase_end_s = (wcnt_r == (width_r - WW'(1)));
      last_ph_s   = dir_r ? (ph_r == '0) : (ph_r == PH_LAST);
      first_ph_s  = dir_r ? PH_LAST : '0;
      case (state_r)
         ST_IDLE: begin
            if (bus.start && !bus.abort) begin
               state_s = ST_RUN;
               load_s  = 1'b1;
               ph_s    = bus.dir ? PH_LAST : '0;
               wcnt_s  = '0;
               gcnt_s  = '0;
               rcnt_s  = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               abort_s = 1'b1;
               state_s = ST_IDLE;
               ph_s    = '0;
               wcnt_s  = '0;
               gcnt_s  = '0;
               rcnt_s  = '0;
            end else if (!phase_end_s) begin
               wcnt_s = wcnt_r + WW'(1);
            end else begin
               wcnt_s = '0;
               if (!last_ph_s) begin
                  ph_s = dir_r ? (ph_r - PW'(1)) : (ph_r + PW'(1));
               end else begin
                  // End of round; a finite burst never gets a trailing gap
                  rcnt_s = rnext_s;
                  if ((rounds_r != {CW{1'b0}}) && (rnext_s == rounds_r)) begin
                     state_s = ST_DONE;
                  end else if (gap_r != {WW{1'b0}}) begin
                     state_s = ST_GAP;
                     gcnt_s  = '0;
                  end else begin
                     ph_s = first_ph_s;
                  end
               end
            end
         end
         ST_GAP: begin
            if (bus.abort) begin
               abort_s = 1'b1;
               state_s = ST_IDLE;
               ph_s    = '0;
               wcnt_s  = '0;
               gcnt_s  = '0;
               rcnt_s  = '0;
            end else if (gcnt_r == (gap_r - WW'(1))) begin
               state_s = ST_RUN;
               ph_s    = first_ph_s;
               gcnt_s  = '0;
            end else begin
               gcnt_s = gcnt_r + WW'(1);
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Core state, counters and configuration captured at the accepting edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= ST_IDLE;
         ph_r     <= '0;
         wcnt_r   <= '0;
         gcnt_r   <= '0;
         rcnt_r   <= '0;
         width_r  <= WW'(1);
         gap_r    <= '0;
         rounds_r <= '0;
         dir_r    <= 1'b0;
      end else begin
         state_r <= state_s;
         ph_r    <= ph_s;
         wcnt_r  <= wcnt_s;
         gcnt_r  <= gcnt_s;
         rcnt_r  <= rcnt_s;
         if (load_s) begin
            width_r  <= (bus.width == {WW{1'b0}}) ? WW'(1) : bus.width;
            gap_r    <= bus.gap;
            rounds_r <= bus.rounds;
            dir_r    <= bus.dir;
         end
      end
   end

   // Registered outputs; abort clears them on the same edge the core leaves RUN/GAP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_r     <= '0;
         phase_r <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else if (abort_s) begin
         q_r     <= '0;
         phase_r <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         q_r     <= (state_r == ST_RUN) ? onehot(ph_r) : '0;
         phase_r <= (state_r == ST_RUN) ? ph_r : '0;
         busy_r  <= (state_r == ST_RUN) || (state_r == ST_GAP);
         done_r  <= (state_r == ST_DONE);
      end
   end

   assign bus.q     = q_r;
   assign bus.phase = phase_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
endmodule

// File: tb/tb_seqplu_sched.sv
// Scoreboard bench for seqplu_sched: bursts push expected per-edge output records, a negedge
// monitor pops and compares them whenever the block shows any activity on its outputs.
module tb_seqplu_sched;
   localparam int NPH = 4;
   localparam int WW  = 4;
   localparam int CW  = 8;

   typedef struct {
      int         edge_n;
      logic [3:0] q;
      logic [1:0] ph;
      logic       busy;
      logic       done;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   last_done = -1;
   rec_t exp_q[$];

   seqplu_sched_if #(.NPH(NPH), .WW(WW), .CW(CW)) bus ();

   seqplu_sched #(.NPH(NPH), .WW(WW), .CW(CW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: any visible output activity must match the next expected record, edge included.
   always @(negedge clk) begin
      if (rst && (bus.busy || bus.done || (bus.q != 4'b0000) || (bus.phase != 2'd0))) begin
         rec_t r;
         if (bus.done) last_done = cyc;
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_output edge=%0d: got q=%b ph=%0d busy=%b done=%b, want no activity",
                     cyc, bus.q, bus.phase, bus.busy, bus.done);
         end else begin
            r = exp_q.pop_front();
            if (r.edge_n != cyc || r.q != bus.q || r.ph != bus.phase ||
                r.busy != bus.busy || r.done != bus.done) begin
               errors = errors + 1;
               $display("FAIL trace: got edge=%0d q=%b ph=%0d busy=%b done=%b, want edge=%0d q=%b ph=%0d busy=%b done=%b",
                        cyc, bus.q, bus.phase, bus.busy, bus.done,
                        r.edge_n, r.q, r.ph, r.busy, r.done);
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      checks = checks + 1;
      if (got != want) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic push(input int e, input logic [3:0] q, input logic [1:0] ph,
                       input logic b, input logic d);
      rec_t r;
      r.edge_n = e; r.q = q; r.ph = ph; r.busy = b; r.done = d;
      exp_q.push_back(r);
   endtask

   // Expected trace of one burst; records at or after the stop edge (abort/reset) are dropped.
   task automatic model(input int k, input int w, input int g, input int rn,
                        input bit d, input int stop);
      int wd, e, rc, idx;
      wd = (w == 0) ? 1 : w;
      e  = k + 1;
      rc = 0;
      while (e < stop) begin
         for (int p = 0; p < NPH; p++) begin
            idx = d ? (NPH - 1 - p) : p;
            for (int x = 0; x < wd; x++) begin
               if (e < stop) push(e, 4'(1 << idx), 2'(idx), 1'b1, 1'b0);
               e++;
            end
         end
         rc++;
         if (rn != 0 && rc == rn) begin
            if (e < stop) push(e, 4'b0000, 2'd0, 1'b0, 1'b1);
            return;
         end
         for (int x = 0; x < g; x++) begin
            if (e < stop) push(e, 4'b0000, 2'd0, 1'b1, 1'b0);
            e++;
         end
      end
   endtask

   // Called at a negedge: start is sampled at the next posedge, edge k.
   task automatic burst(input int w, input int g, input int rn, input bit d,
                        input int stop_rel, output int k);
      k = cyc + 1;
      bus.start  = 1'b1;
      bus.width  = WW'(w);
      bus.gap    = WW'(g);
      bus.rounds = CW'(rn);
      bus.dir    = d;
      last_done  = -1;
      model(k, w, g, rn, d, (stop_rel == 0) ? 32'h7fff_ffff : k + stop_rel);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_until(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_q"},     int'(bus.q),     0);
      check({tag, "_phase"}, int'(bus.phase), 0);
      check({tag, "_busy"},  int'(bus.busy),  0);
      check({tag, "_done"},  int'(bus.done),  0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      bus.start = 1'b0; bus.abort = 1'b0; bus.width = 4'd0; bus.gap = 4'd0;
      bus.rounds = 8'd0; bus.dir = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      rst = 1'b1;
      @(negedge clk);

      // Single round, width 1
      burst(1, 0, 1, 1'b0, 0, k);
      wait_until(k + 7);
      check("single_done_edge", last_done - k, 5);

      // Width 3, gap 2, two rounds
      burst(3, 2, 2, 1'b0, 0, k);
      wait_until(k + 29);
      check("wgap_done_edge", last_done - k, 27);

      // Width 0 behaves as width 1
      burst(0, 0, 1, 1'b0, 0, k);
      wait_until(k + 7);
      check("zero_width_done_edge", last_done - k, 5);

      // Reverse direction, width 2
      burst(2, 0, 1, 1'b1, 0, k);
      wait_until(k + 11);
      check("reverse_done_edge", last_done - k, 9);

      // Continuous mode, abort sampled at edge k+10
      burst(1, 0, 0, 1'b0, 10, k);
      wait_until(k + 9);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_q", int'(bus.q), 0);
      check("abort_busy", int'(bus.busy), 0);
      wait_until(k + 11);
      check("abort_no_done", last_done, -1);
      begin
         int k0;
         k0 = k;
         burst(1, 0, 1, 1'b0, 0, k);
         check("restart_edge", k - k0, 12);
      end
      wait_until(k + 7);
      check("restart_done_edge", last_done - k, 5);

      // Starts during RUN and at the completing edge are ignored
      burst(1, 0, 1, 1'b0, 0, k);
      wait_until(k + 1);
      bus.start = 1'b1; bus.width = 4'd5; bus.dir = 1'b1; bus.rounds = 8'd3; bus.gap = 4'd2;
      @(negedge clk);
      bus.start = 1'b0;
      wait_until(k + 4);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_until(k + 12);
      check("ignored_done_edge", last_done - k, 5);
      check("ignored_busy_after", int'(bus.busy), 0);

      // Start together with abort in IDLE stays idle
      bus.start = 1'b1; bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      repeat (4) @(negedge clk);
      check("start_abort_busy", int'(bus.busy), 0);
      check("start_abort_q", int'(bus.q), 0);

      // Asynchronous reset between edges k+2 and k+3
      burst(1, 0, 1, 1'b0, 3, k);
      wait_until(k + 2);
      #1 rst = 1'b0;
      #1 check_idle_outputs("async_reset");
      @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      check("reset_no_done", last_done, -1);

      // Normal burst after reset
      burst(1, 0, 1, 1'b0, 0, k);
      wait_until(k + 7);
      check("post_reset_done_edge", last_done - k, 5);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
